// File: rtl/output_layer_accum_pkg.sv
// Shared sizing defaults and FSM encoding for the output layer
// accumulator and the max selector that consumes its scores.
package output_layer_accum_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int ACC_W_DEF       = 26;
   localparam int IN_W_DEF        = 16;
   localparam int CLASS_W         = 4;
   localparam int OUT_PORTS       = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/output_layer_accum_acc_add.sv
// One class-score adder: sign-extend a term and add it to a score.
// Saturates when OUTPUT_ACC_SATURATE_EN is defined, wraps otherwise.
module acc_add
   import output_layer_accum_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int IN_W  = IN_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [IN_W-1:0]  term,
   output logic signed [ACC_W-1:0] sum
);

`ifdef OUTPUT_ACC_SATURATE_EN
   localparam logic [ACC_W-1:0] MAX_V =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V =
      {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] wide;

   // one guard bit exposes overflow in either direction
   assign wide = {acc[ACC_W-1], acc}
               + {{(ACC_W+1-IN_W){term[IN_W-1]}}, term};

   always_comb begin
      sum = wide[ACC_W-1:0];
      if (wide[ACC_W] != wide[ACC_W-1])
         sum = wide[ACC_W] ? MIN_V : MAX_V;
   end
`else
   logic [ACC_W-1:0] ext;

   assign ext = {{(ACC_W-IN_W){term[IN_W-1]}}, term};
   assign sum = acc + ext;
`endif

endmodule

// File: rtl/output_layer_accum.sv
// Accumulates per-class product terms of one image into class scores.
// Optional saturation of every add: define OUTPUT_ACC_SATURATE_EN.
module output_layer_accum
   import output_layer_accum_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int IN_W        = IN_W_DEF
) (
   input  logic                    clk,
   input  logic                    GlobalReset,
   input  logic                    In_valid,
   output logic                    In_ready,
   input  logic [CLASS_W-1:0]      In_class,
   input  logic signed [IN_W-1:0]  In_data,
   input  logic                    In_last,
   output logic signed [ACC_W-1:0] Out_0,
   output logic signed [ACC_W-1:0] Out_1,
   output logic signed [ACC_W-1:0] Out_2,
   output logic signed [ACC_W-1:0] Out_3,
   output logic signed [ACC_W-1:0] Out_4,
   output logic signed [ACC_W-1:0] Out_5,
   output logic signed [ACC_W-1:0] Out_6,
   output logic signed [ACC_W-1:0] Out_7,
   output logic signed [ACC_W-1:0] Out_8,
   output logic signed [ACC_W-1:0] Out_9,
   output logic                    Out_valid,
   output logic                    Err_class
);

   localparam int NC = (NUM_CLASSES < OUT_PORTS) ?
                       NUM_CLASSES : OUT_PORTS;

   acc_state_t state;
   logic       accept;
   logic       load;
   logic       bad_class;
   logic signed [ACC_W-1:0] out_r [OUT_PORTS];

   assign In_ready  = (state != ST_DONE) && !GlobalReset;
   assign accept    = In_valid && In_ready;
   assign load      = accept && In_last;
   assign bad_class = In_class > CLASS_W'(NC-1);

   for (genvar k = 0; k < OUT_PORTS; k++) begin : g_cls
      if (k < NC) begin : g_on
         logic signed [ACC_W-1:0] acc;
         logic signed [ACC_W-1:0] sum;
         logic signed [ACC_W-1:0] score;
         logic                    hit;

         assign hit = accept && (In_class == CLASS_W'(k));

         acc_add #(
            .ACC_W(ACC_W),
            .IN_W (IN_W)
         ) u_add (
            .acc (acc),
            .term(In_data),
            .sum (sum)
         );

         // the last term is folded into the score while the sum clears
         always_ff @(posedge clk) begin
            if (GlobalReset) begin
               acc   <= '0;
               score <= '0;
            end else if (load) begin
               acc   <= '0;
               score <= hit ? sum : acc;
            end else if (hit) begin
               acc   <= sum;
            end
         end

         assign out_r[k] = score;
      end else begin : g_off
         assign out_r[k] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         state     <= ST_IDLE;
         Out_valid <= 1'b0;
         Err_class <= 1'b0;
      end else begin
         Out_valid <= load;
         if (accept && bad_class)
            Err_class <= 1'b1;
         case (state)
            ST_IDLE:
               if (accept)
                  state <= In_last ? ST_DONE : ST_ACCUM;
            ST_ACCUM:
               if (load)
                  state <= ST_DONE;
            ST_DONE:
               state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   assign Out_0 = out_r[0];
   assign Out_1 = out_r[1];
   assign Out_2 = out_r[2];
   assign Out_3 = out_r[3];
   assign Out_4 = out_r[4];
   assign Out_5 = out_r[5];
   assign Out_6 = out_r[6];
   assign Out_7 = out_r[7];
   assign Out_8 = out_r[8];
   assign Out_9 = out_r[9];

endmodule

// File: tb/tb_output_layer_accum.sv
// Directed and random checks of output_layer_accum against a
// plain-arithmetic score model (honours OUTPUT_ACC_SATURATE_EN).
module tb_output_layer_accum;

   localparam longint ACC_MAX = 64'sd33554431;
   localparam longint ACC_MIN = -64'sd33554432;
   localparam longint MOD     = 64'sd67108864;

   logic clk = 1'b0;
   logic GlobalReset = 1'b1;
   logic In_valid = 1'b0;
   logic In_ready;
   logic [3:0] In_class = '0;
   logic signed [15:0] In_data = '0;
   logic In_last = 1'b0;
   logic signed [25:0] Out_0, Out_1, Out_2, Out_3, Out_4;
   logic signed [25:0] Out_5, Out_6, Out_7, Out_8, Out_9;
   logic Out_valid;
   logic Err_class;

   int n_assert = 0;
   int n_fail   = 0;

   longint sums    [10];
   longint exp_out [10];
   bit     exp_err;

   output_layer_accum dut (
      .clk        (clk),
      .GlobalReset(GlobalReset),
      .In_valid   (In_valid),
      .In_ready   (In_ready),
      .In_class   (In_class),
      .In_data    (In_data),
      .In_last    (In_last),
      .Out_0      (Out_0),
      .Out_1      (Out_1),
      .Out_2      (Out_2),
      .Out_3      (Out_3),
      .Out_4      (Out_4),
      .Out_5      (Out_5),
      .Out_6      (Out_6),
      .Out_7      (Out_7),
      .Out_8      (Out_8),
      .Out_9      (Out_9),
      .Out_valid  (Out_valid),
      .Err_class  (Err_class)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs,
                      input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   function automatic longint get_out(input int k);
      case (k)
         0: return longint'(Out_0);
         1: return longint'(Out_1);
         2: return longint'(Out_2);
         3: return longint'(Out_3);
         4: return longint'(Out_4);
         5: return longint'(Out_5);
         6: return longint'(Out_6);
         7: return longint'(Out_7);
         8: return longint'(Out_8);
         default: return longint'(Out_9);
      endcase
   endfunction

   function automatic longint madd(input longint a,
                                   input longint d);
      longint s;
      s = a + d;
`ifdef OUTPUT_ACC_SATURATE_EN
      if (s > ACC_MAX) s = ACC_MAX;
      if (s < ACC_MIN) s = ACC_MIN;
`else
      s = s % MOD;
      if (s < 0) s = s + MOD;
      if (s > ACC_MAX) s = s - MOD;
`endif
      return s;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 10; k++) begin
         sums[k]    = 0;
         exp_out[k] = 0;
      end
      exp_err = 1'b0;
   endtask

   task automatic check_outs(input string tag);
      for (int k = 0; k < 10; k++)
         chk($sformatf("%s_out%0d", tag, k), get_out(k),
             exp_out[k]);
   endtask

   task automatic idle(input int n);
      In_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      In_valid    = 1'b0;
      GlobalReset = 1'b1;
      tick();
      chk("rst_ready", In_ready, 0);
      GlobalReset = 1'b0;
      tick();
      model_clear();
      chk("rst_valid", Out_valid, 0);
      chk("rst_err", Err_class, 0);
      chk("rst_ready_after", In_ready, 1);
      check_outs("rst");
   endtask

   task automatic send(input int cls, input longint d,
                       input bit last, output int waited);
      In_valid = 1'b1;
      In_class = 4'(cls);
      In_data  = 16'(d);
      In_last  = last;
      waited   = 0;
      while (In_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk("ready_bound", In_ready, 1);
      tick();
      if (cls < 10) sums[cls] = madd(sums[cls], d);
      else exp_err = 1'b1;
      if (last) begin
         for (int k = 0; k < 10; k++) begin
            exp_out[k] = sums[k];
            sums[k]    = 0;
         end
         chk("last_valid", Out_valid, 1);
         chk("done_ready", In_ready, 0);
         chk("last_err", Err_class, longint'(exp_err));
         check_outs("img");
      end else begin
         chk("mid_valid", Out_valid, 0);
         chk("mid_hold", get_out(cls % 10), exp_out[cls % 10]);
      end
   endtask

   initial begin
      int w;
      int n;
      int cls;
      logic signed [15:0] r16;
      longint exp_sat;

      model_clear();
      tick();
      chk("init_ready", In_ready, 0);
      do_reset();

      // three-term image with known scores
      send(3, 100, 0, w);
      send(3, 50, 0, w);
      send(7, -20, 1, w);
      chk("d_out3", longint'(Out_3), 150);
      chk("d_out7", longint'(Out_7), -20);
      chk("d_out0", longint'(Out_0), 0);
      idle(1);
      chk("d_pulse_end", Out_valid, 0);
      chk("d_hold3", longint'(Out_3), 150);

      // back-to-back random images, valid held high
      for (int img = 0; img < 4; img++) begin
         n = $urandom_range(1, 8);
         for (int t = 0; t < n; t++) begin
            cls = $urandom_range(0, 9);
            r16 = 16'($urandom);
            send(cls, longint'(r16), t == n - 1, w);
            if (t == 0 && img > 0)
               chk("b2b_wait", w, 1);
         end
      end

      // random images with idle gaps
      for (int img = 0; img < 5; img++) begin
         n = $urandom_range(1, 12);
         for (int t = 0; t < n; t++) begin
            cls = $urandom_range(0, 9);
            r16 = 16'($urandom);
            send(cls, longint'(r16), t == n - 1, w);
            if ($urandom_range(0, 2) == 0) idle(1);
         end
      end
      idle(1);

      // out-of-range class
      do_reset();
      send(12, 5, 1, w);
      chk("e_err", Err_class, 1);
      send(2, 9, 1, w);
      chk("e_sticky", Err_class, 1);
      chk("e_out2", longint'(Out_2), 9);
      idle(1);
      do_reset();

      // reset mid-image, overriding an offered last term
      for (int t = 0; t < 5; t++)
         send(t, 1000 + t, 0, w);
      In_valid    = 1'b1;
      In_class    = 4'd2;
      In_data     = 16'sd7;
      In_last     = 1'b1;
      GlobalReset = 1'b1;
      tick();
      chk("mr_ready", In_ready, 0);
      GlobalReset = 1'b0;
      In_valid    = 1'b0;
      model_clear();
      tick();
      chk("mr_valid", Out_valid, 0);
      check_outs("mr");
      tick();
      chk("mr_valid2", Out_valid, 0);
      send(4, 33, 0, w);
      send(1, -3, 1, w);

      // single-term image
      idle(1);
      send(9, -1, 1, w);
      chk("s_out9", longint'(Out_9), -1);
      idle(1);
      chk("s_valid_end", Out_valid, 0);
      chk("s_idle_ready", In_ready, 1);

      // long run on class 0: saturate or wrap
      do_reset();
      for (int t = 0; t < 2048; t++)
         send(0, 32767, t == 2047, w);
`ifdef OUTPUT_ACC_SATURATE_EN
      exp_sat = 33554431;
`else
      exp_sat = -2048;
`endif
      chk("big_out0", longint'(Out_0), exp_sat);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/output_layer_accum.md
OUTPUT_LAYER_ACCUM -- requirements
Module: output_layer_accum

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, number of class scores.
REQ-002 The block SHALL have parameter ACC_W, default 26, width of each signed class score.
REQ-003 The block SHALL have parameter IN_W, default 16, width of each signed product term.
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-005 The block SHALL have port GlobalReset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port In_valid, input, 1, product term present.
REQ-007 The block SHALL have port In_ready, output, 1, block accepts a term this cycle.
REQ-008 The block SHALL have port In_class, input, 4, target class index of the term.
REQ-009 The block SHALL have port In_data, input, IN_W, signed product term.
REQ-010 The block SHALL have port In_last, input, 1, final term of the current image.
REQ-011 The block SHALL have ports Out_0 .. Out_9, output, ACC_W each, signed final class scores feeding the max selector.
REQ-012 The block SHALL have port Out_valid, output, 1, one-cycle pulse marking new Out_0..Out_9.
REQ-013 The block SHALL have port Err_class, output, 1, sticky flag for an accepted In_class > 9.

Function
REQ-014 A term SHALL be accepted on a rising edge where In_valid and In_ready are both 1.
REQ-015 FSM states SHALL be IDLE, ACCUM, DONE; In_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE.
REQ-016 IDLE -> ACCUM on accepting a term with In_last=0; IDLE or ACCUM -> DONE on accepting a term with In_last=1; DONE -> IDLE unconditionally after one cycle.
REQ-017 An accepted term SHALL add sign-extended In_data to accumulator In_class; other accumulators SHALL be unchanged.
REQ-018 On the edge accepting the In_last term, Out_k SHALL load accumulator k including that term, all accumulators SHALL clear to 0, and Out_valid SHALL be 1 for exactly the following cycle (latency 1 cycle).
REQ-019 Out_0..Out_9 SHALL hold their values until the next In_last acceptance.
REQ-020 An accepted term with In_class > 9 SHALL update no accumulator, SHALL set Err_class, and SHALL still honour In_last.
REQ-021 A single-term image (In_last on first term in IDLE) SHALL produce scores equal to that term alone.
REQ-022 In_valid while In_ready=0 SHALL be ignored; the source holds the term until accepted.

Reset
REQ-023 With GlobalReset=1 at a rising edge, state SHALL go to IDLE, accumulators and Out_0..Out_9 SHALL be 0, Out_valid and Err_class SHALL be 0.
REQ-024 Reset mid-image (ACCUM or DONE) SHALL discard partial sums with no Out_valid pulse; reset SHALL override a simultaneous accepted term.
REQ-025 In_ready SHALL be 0 in any cycle GlobalReset is 1.

Configuration
REQ-026 With macro OUTPUT_ACC_SATURATE_EN defined, each add SHALL saturate to the ACC_W signed range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
REQ-027 Without OUTPUT_ACC_SATURATE_EN, each add SHALL wrap modulo 2^ACC_W.

Structure
REQ-028 NUM_CLASSES, ACC_W, IN_W defaults and the FSM state encoding SHALL live in a shared package used by this block and the max selector.
REQ-029 The per-class add (sign-extend, add, optional saturate) SHALL be one sub-module, acc_add, instantiated NUM_CLASSES times.

Verification
REQ-030 Reset then terms (class 3, +100), (class 3, +50), (class 7, -20, last) -> one cycle later Out_valid=1, Out_3=150, Out_7=-20, others 0.
REQ-031 Back-to-back images with In_valid held high -> In_ready=0 exactly one cycle after each last term; second image sums exclude first image's terms.
REQ-032 Term (class 12, +5, last) -> Err_class=1, all outputs 0, Out_valid pulses; Err_class stays 1 until reset.
REQ-033 With OUTPUT_ACC_SATURATE_EN, 2048 terms of +32767 to class 0 -> Out_0=33554431; without macro -> Out_0 wraps to -33554432+65536*... per modulo 2^26 model.
REQ-034 GlobalReset asserted after 5 ACCUM terms -> no Out_valid, outputs 0, next image sums start from 0.
REQ-035 Single term (class 9, -1, last) from IDLE -> Out_9=-1, Out_valid one cycle, state back to IDLE after two cycles.
